imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate sign-extend/decode unit: packs a 32-bit immediate into the B/S/I/R instruction-word bit positions of a base instruction word.
- Range-checks the immediate and flags any value that cannot be represented in the chosen format.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Used by the boot/self-test instruction generator and by the trap-return stub builder to synthesise branches, stores and ALU-immediate instructions.

Parameters:
- ERRCNT_W, 16, width of the saturating error counter

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- fmt  input  2  format, same `EXTNR_B/S/I/R codes as the decoder (defs.v)
- imm  input  `WORDSIZE  signed immediate value
- base  input  `WORDSIZE  instruction word carrying opcode/rd/rs1/rs2/funct fields; bits in immediate positions are ignored
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- insn  output  `WORDSIZE  encoded instruction
- err  output  1  immediate out of range for fmt; qualified by out_valid
- err_cnt  output  ERRCNT_W  saturating count of delivered results with err=1

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, insn=0, err=0, err_cnt=0.
- Reset mid-operation discards all in-flight requests. No output handshake for them.
- Stage 1 (range check), registered on accept: capture fmt, imm, base, and a computed range-error bit.
  - I, S: err if imm < -2048 or imm > 2047.
  - B: err if imm < -4096 or imm > 4094, or imm[0]=1.
  - R: err if imm != 0.
- Stage 2 (assemble), registered from s1. Start from base, clear the immediate field bits for fmt, then OR in imm bits:
  - I: insn[31:20]=imm[11:0].
  - S: insn[31:25]=imm[11:5]; insn[11:7]=imm[4:0].
  - B: insn[31]=imm[12]; insn[7]=imm[11]; insn[30:25]=imm[10:5]; insn[11:8]=imm[4:1].
  - R: insn=base unchanged.
- On err, insn is still produced using the truncated low bits of imm. err=1 accompanies it.
- Latency: exactly 2 cycles from accept to out_valid when not stalled. Throughput is 1 per cycle.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advance.
  - in_ready = !s1_valid || s2 advance. Combinational from out_ready, with no skid.
- Stall: insn, err and out_valid hold stable while out_valid && !out_ready. The pipeline holds 2 entries, then in_ready=0.
- No loss, duplication or reordering under any valid/ready pattern.
- Simultaneous accept and deliver in the same cycle are both honoured.
- err_cnt increments on output handshake with err=1 and saturates at all-ones, no wrap.
- in_valid with in_ready=0 has no effect. The source must hold its inputs.

Test Plan:
- Reset then fmt=I, imm=-1 (0xFFFFFFFF), base=0x00000013, out_ready=1 -> after 2 cycles out_valid=1, insn=0xFFF00013, err=0.
- fmt=S, imm=-4, base=0x00002023 -> insn=0xFE002E23, err=0. Same with base=0xFFFFFFFF in S-field bits -> S-field bits replaced, insn identical in those bits.
- fmt=B, imm=-8, base=0x00000063 -> insn=0xFE000CE3, err=0.
  - Then imm=3 -> err=1.
  - Then imm=4096 -> err=1.
  - err_cnt=2 after both delivered.
- fmt=I imm=2048 -> err=1. fmt=R imm=0, base=0x00B50533 -> insn=0x00B50533, err=0. fmt=R imm=1 -> err=1.
- Back-to-back 4 requests with out_ready low for cycles 2-5 -> in_ready drops after 2 held entries; all 4 delivered in order once out_ready=1; outputs stable while stalled.
- Assert rst_n low mid-stream with 2 entries in flight -> out_valid=0 immediately, err_cnt=0, no stale output after release. Force err_cnt to all-ones, then one error -> remains all-ones.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into the I/S/B/R field positions of a
// base instruction word, flags out-of-range values, two-stage valid/ready pipeline.
package imm_encoder_pkg;
  localparam int WORDSIZE = 32;

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2,
    FMT_R = 2'd3
  } fmt_e;
endpackage

module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          fmt,
  input  logic [WORDSIZE-1:0] imm,
  input  logic [WORDSIZE-1:0] base,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] insn,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  logic                s1_valid;
  fmt_e                s1_fmt;
  logic [12:0]         s1_imm;
  logic [WORDSIZE-1:0] s1_base;
  logic                s1_err;

  logic                s2_adv;
  logic                s1_adv;
  logic                range_err;
  logic [WORDSIZE-1:0] asm_insn;

  // Stage 2 empties or drains; stage 1 may move whenever stage 2 makes room.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    range_err = 1'b0;
    case (fmt_e'(fmt))
      FMT_I, FMT_S: range_err = ($signed(imm) < -2048) || ($signed(imm) > 2047);
      FMT_B:        range_err = ($signed(imm) < -4096) || ($signed(imm) > 4094) || imm[0];
      FMT_R:        range_err = |imm;
      default:      range_err = 1'b0;
    endcase
  end

  // Overwriting the field bits is the same as clearing them in base and OR-ing imm in.
  always_comb begin
    asm_insn = s1_base;
    case (s1_fmt)
      FMT_I: asm_insn[31:20] = s1_imm[11:0];
      FMT_S: begin
        asm_insn[31:25] = s1_imm[11:5];
        asm_insn[11:7]  = s1_imm[4:0];
      end
      FMT_B: begin
        asm_insn[31]    = s1_imm[12];
        asm_insn[30:25] = s1_imm[10:5];
        asm_insn[11:8]  = s1_imm[4:1];
        asm_insn[7]     = s1_imm[11];
      end
      default: asm_insn = s1_base;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= FMT_I;
      s1_imm   <= '0;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt  <= fmt_e'(fmt);
        s1_imm  <= imm[12:0];
        s1_base <= base;
        s1_err  <= range_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      insn      <= '0;
      err       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        insn <= asm_insn;
        err  <= s1_err;
      end
    end
  end

  // Counts delivered errored results; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, stalls, random traffic,
// mid-stream reset and counter saturation, against a bit-placement reference model.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    fmt;
  logic [31:0]   imm;
  logic [31:0]   base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   insn;
  logic          err;
  logic [CW-1:0] err_cnt;

  imm_encoder #(.ERRCNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .insn      (insn),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [1:0]  f;
    logic [31:0] i;
    logic [31:0] b;
    logic [31:0] insn;
    logic        e;
  } vec_t;

  int   errors  = 0;
  int   checks  = 0;
  int   exp_cnt = 0;
  exp_t q[$];

  // Reference: signed-range rules plus an imm-bit -> insn-bit placement map.
  function automatic exp_t model(input logic [1:0] f, input logic [31:0] i, input logic [31:0] b);
    exp_t r;
    int   v;
    int   dst;
    v      = $signed(i);
    r.insn = b;
    r.err  = 1'b0;
    case (f)
      FMT_I: begin
        r.err = (v < -2048) || (v > 2047);
        for (int k = 0; k < 12; k++) r.insn[20+k] = i[k];
      end
      FMT_S: begin
        r.err = (v < -2048) || (v > 2047);
        for (int k = 0; k < 5; k++) r.insn[7+k] = i[k];
        for (int k = 5; k < 12; k++) r.insn[20+k] = i[k];
      end
      FMT_B: begin
        r.err = (v < -4096) || (v > 4094) || ((v % 2) != 0);
        for (int k = 1; k <= 12; k++) begin
          if (k == 12)     dst = 31;
          else if (k == 11) dst = 7;
          else if (k < 5)   dst = k + 7;
          else              dst = k + 20;
          r.insn[dst] = i[k];
        end
      end
      default: r.err = (v != 0);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_imm();
    int sel;
    int edges[12];
    edges = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096, 0, 1, -1};
    sel = $urandom % 4;
    case (sel)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 10000) - 5000);
      2:       return 32'(edges[$urandom % 12]);
      default: return 32'd0;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] f, input logic [31:0] i, input logic [31:0] b, input exp_t e);
    in_valid = 1'b1;
    fmt      = f;
    imm      = i;
    base     = b;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fmt      = 2'($urandom);
        imm      = $urandom;
        base     = $urandom;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready=%b required=1 within 200 cycles", in_ready);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for a delivery with out_ready held high and compares it.
  task automatic expect_out(input string name, output int lat);
    exp_t e;
    lat = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got insn=%h err=%b, required no output", name, insn, err);
        end else begin
          e = q.pop_front();
          if (insn !== e.insn || err !== e.err) begin
            errors++;
            $display("FAIL %s: got insn=%h err=%b, required insn=%h err=%b", name, insn, err, e.insn, e.err);
          end
          if (e.err && exp_cnt < CNT_MAX) exp_cnt++;
        end
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: out_valid=%b required=1 within 200 cycles", name, out_valid);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fmt       = 2'd0;
    imm       = '0;
    base      = '0;
    q.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || insn !== 32'h0 || err !== 1'b0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got out_valid=%b insn=%h err=%b err_cnt=%0d, required 0/0/0/0",
               out_valid, insn, err, err_cnt);
    end
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t v[14];
    int   lat;
    v[0]  = '{FMT_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    v[1]  = '{FMT_S, 32'hFFFF_FFFC, 32'h0000_2023, 32'hFE00_2E23, 1'b0};
    v[2]  = '{FMT_S, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FE7F, 1'b0};
    v[3]  = '{FMT_B, 32'hFFFF_FFF8, 32'h0000_0063, 32'hFE00_0CE3, 1'b0};
    v[4]  = '{FMT_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
    v[5]  = '{FMT_B, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1};
    v[6]  = '{FMT_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    v[7]  = '{FMT_R, 32'h0000_0000, 32'h00B5_0533, 32'h00B5_0533, 1'b0};
    v[8]  = '{FMT_R, 32'h0000_0001, 32'h0000_0033, 32'h0000_0033, 1'b1};
    v[9]  = '{FMT_I, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
    v[10] = '{FMT_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
    v[11] = '{FMT_I, 32'hFFFF_F7FF, 32'h0000_0013, 32'h7FF0_0013, 1'b1};
    v[12] = '{FMT_B, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0};
    v[13] = '{FMT_B, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      send(v[k].f, v[k].i, v[k].b, '{v[k].insn, v[k].e});
      expect_out($sformatf("directed_%0d", k), lat);
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL latency_%0d: got %0d cycles, required 2", k, lat);
      end
      checks++;
      if (err_cnt !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL err_cnt_%0d: got %0d, required %0d", k, err_cnt, exp_cnt);
      end
      if (k == 5) begin
        checks++;
        if (err_cnt !== CW'(2)) begin
          errors++;
          $display("FAIL err_cnt_two: got %0d, required 2", err_cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  f[4];
    logic [31:0] i[4];
    logic [31:0] b[4];
    for (int k = 0; k < 4; k++) begin
      f[k] = 2'($urandom);
      i[k] = rand_imm();
      b[k] = $urandom;
    end
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(f[k], i[k], b[k], model(f[k], i[k], b[k]));
      end
      begin
        logic [31:0] h_insn;
        logic        h_err;
        int          lat;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_full: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
        end
        h_insn = insn;
        h_err  = err;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (insn !== h_insn || err !== h_err || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got insn=%h err=%b ov=%b ir=%b, required insn=%h err=%b ov=1 ir=0",
                     insn, err, out_valid, in_ready, h_insn, h_err);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) expect_out($sformatf("b2b_%0d", k), lat);
      end
    join
    checks++;
    if (err_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL b2b_err_cnt: got %0d, required %0d", err_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    localparam int N = 200;
    int got = 0;
    fork
      begin
        logic [1:0]  f;
        logic [31:0] i;
        logic [31:0] b;
        for (int k = 0; k < N; k++) begin
          if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
          end
          f = 2'($urandom);
          i = rand_imm();
          b = $urandom;
          send(f, i, b, model(f, i, b));
        end
      end
      begin
        exp_t        e;
        logic        held = 1'b0;
        logic [31:0] h_insn = '0;
        logic        h_err = 1'b0;
        for (int c = 0; c < 5000 && got < N; c++) begin
          out_ready = ($urandom % 3 != 0);
          @(negedge clk);
          if (held) begin
            checks++;
            if (out_valid !== 1'b1 || insn !== h_insn || err !== h_err) begin
              errors++;
              $display("FAIL rand_stall: got ov=%b insn=%h err=%b, required ov=1 insn=%h err=%b",
                       out_valid, insn, err, h_insn, h_err);
            end
          end
          held = out_valid && !out_ready;
          h_insn = insn;
          h_err  = err;
          if (out_valid && out_ready) begin
            checks++;
            got++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL rand_extra: got insn=%h err=%b, required no output", insn, err);
            end else begin
              e = q.pop_front();
              if (insn !== e.insn || err !== e.err) begin
                errors++;
                $display("FAIL rand_%0d: got insn=%h err=%b, required insn=%h err=%b",
                         got, insn, err, e.insn, e.err);
              end
              if (e.err && exp_cnt < CNT_MAX) exp_cnt++;
            end
          end
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (got != N) begin
      errors++;
      $display("FAIL rand_count: got %0d deliveries, required %0d", got, N);
    end
    checks++;
    if (err_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL rand_err_cnt: got %0d, required %0d", err_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b1;
    send(FMT_R, 32'd5, 32'h33, model(FMT_R, 32'd5, 32'h33));
    begin
      int lat;
      expect_out("pre_reset", lat);
    end
    checks++;
    if (err_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL pre_reset_cnt: got %0d, required 1", err_cnt);
    end
    out_ready = 1'b0;
    send(FMT_I, 32'd7, 32'h13, model(FMT_I, 32'd7, 32'h13));
    send(FMT_B, 32'd8, 32'h63, model(FMT_B, 32'd8, 32'h63));
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: got ov=%b err_cnt=%0d ir=%b, required 0/0/1", out_valid, err_cnt, in_ready);
    end
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_output: got out_valid=%b insn=%h, required out_valid=0", out_valid, insn);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    int lat;
    do_reset();
    for (int k = 0; k < CNT_MAX + 3; k++) begin
      send(FMT_R, 32'd1, 32'h0000_0033, model(FMT_R, 32'd1, 32'h0000_0033));
      expect_out($sformatf("sat_%0d", k), lat);
      checks++;
      if (err_cnt !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_cnt_%0d: got %0d, required %0d", k, err_cnt, exp_cnt);
      end
    end
    checks++;
    if (err_cnt !== CW'(CNT_MAX)) begin
      errors++;
      $display("FAIL sat_final: got %0d, required %0d", err_cnt, CNT_MAX);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fmt       = 2'd0;
    imm       = '0;
    base      = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
